seq_booth_divider: RTL and testbench
====================================

// Module: seq_booth_divider
// PURPOSE
//  Sequential signed integer divider, the inverse operation of the team's Booth multiplier.
//  Computes quotient and remainder of two WIDTH-bit two's-complement operands.
//  Uses radix-2 non-restoring division on magnitudes, then applies sign correction.
//  Driven by a start/busy/done handshake; sits beside the multiplier in the arithmetic unit.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits (two's complement); must be >= 4
// PORTS
//  clk           in   1      single clock, all state changes on its rising edge
//  rst           in   1      synchronous reset, active high
//  start         in   1      request; sampled only in IDLE
//  dividend      in   WIDTH  signed; captured on the accepted start
//  divisor       in   WIDTH  signed; captured on the accepted start
//  busy          out  1      high from the cycle after acceptance until done
//  done          out  1      one-cycle pulse; results are valid from this cycle
//  quotient      out  WIDTH  signed; held until the next accepted start
//  remainder     out  WIDTH  signed; held until the next accepted start
//  div_by_zero   out  1      flag for the current result; held with the result
//  overflow      out  1      flag for dividend=MIN, divisor=-1; held with the result
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow are all 0.
//  - Reset mid-operation aborts the division with no done pulse.
//  - Semantics match C: quotient truncates toward zero; remainder takes the sign of the dividend.
//    Invariant: dividend == quotient*divisor + remainder, and |remainder| < |divisor|.
//  - FSM: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE.
//    IDLE: if start=1, latch the operands, sign_q = sign(dvd)^sign(dvs), sign_r = sign(dvd).
//    PREP: take magnitudes in WIDTH+1 bits so that |MIN| is representable; clear partial remainder;
//      counter = WIDTH-1.
//    ITER: each cycle, shift {R,Q} left by 1; if R >= 0, R -= D, else R += D;
//      set Q[0] = ~R_new[sign]; decrement counter; leave after counter reaches 0.
//    FIX: if R < 0, R += D; apply signs; register outputs and flags; done=1 for this one transition.
//  - Latency: start sampled at edge N -> done=1 in the cycle after edge N+WIDTH+2.
//    busy=1 during PREP, ITER and FIX.
//  - Latency is fixed, including the special cases.
//  - Special cases, resolved in FIX:
//    divisor=0       -> quotient = all ones (-1), remainder = dividend, div_by_zero=1.
//    MIN / -1        -> quotient = MIN, remainder = 0, overflow = 1.
//    dividend = 0    -> quotient = 0, remainder = 0, both flags 0.
//  - start while busy is ignored; the operands are not re-sampled.
//  - start=1 in the same cycle as done is not accepted; it is accepted one cycle after done
//    (back-to-back operations have a 1-cycle gap).
//  - Flags and results update only in FIX. Outside FIX and reset, the outputs never change.
// STRUCTURE
//  - Shared package div_pkg:
//    state enum {IDLE, PREP, ITER, FIX};
//    DIV_WIDTH_DEFAULT = 32;
//    function abs_ext(x) -> WIDTH+1 magnitude;
//    constant MIN_VAL = 1 << (WIDTH-1).
//  - One sub-module, div_nr_step: combinational single non-restoring step
//    (R_in, Q_in, D -> R_out, Q_out); instantiated once and iterated by the FSM.
//  - Counter width is $clog2(WIDTH).
// TESTING
//  Check the invariant and timing on every done; a reference model computes the C-style result.
//  1. 60 / 5        -> q=12,  r=0;  done exactly WIDTH+3 cycles after the start edge; busy low after.
//  2. -10 / 2 -> q=-5, r=0.  7 / -2 -> q=-3, r=1.  -7 / 2 -> q=-3, r=-1.  -20 / -11 -> q=1, r=-9.
//  3. 100 / 0       -> q=-1, r=100, div_by_zero=1, overflow=0; same latency.
//  4. -2147483648 / -1 -> q=-2147483648, r=0, overflow=1.
//     -2147483648 / 1  -> q=-2147483648, r=0, no flags.
//  5. start pulsed while busy with 9 / 3 during 60 / 5 -> a single done, result 12/0;
//     start asserted during done is ignored.
//  6. rst=1 at ITER cycle 10 -> all outputs 0 the next cycle, no done;
//     then 2147483647 / -2147483648 -> q=0, r=2147483647.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
//   state_t            : divider FSM states
//   DIV_WIDTH_DEFAULT  : default operand width
//   abs_ext()          : two's-complement magnitude, one bit wider than the input
//                        so that the most negative value is representable
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // abs_ext works on a 64-bit sign-extended value; callers size-cast the
    // result down to WIDTH+1 bits (supports WIDTH up to 64).
    localparam int ABS_W = 64;

    function automatic logic [ABS_W:0] abs_ext(input logic [ABS_W-1:0] x);
        logic [ABS_W:0] ext;
        ext = {x[ABS_W-1], x};
        return x[ABS_W-1] ? -ext : ext;
    endfunction

endpackage

// File: rtl/div_nr_step.sv
// One radix-2 non-restoring division step (combinational).
//   r_in  : signed partial remainder, W+2 bits
//   q_in  : quotient/dividend shift register, W bits
//   d     : divisor magnitude, W+1 bits
//   r_out : updated partial remainder
//   q_out : q_in shifted left with the new quotient bit in bit 0
module div_nr_step #(
    parameter int W = 32
) (
    input  logic [W+1:0] r_in,
    input  logic [W-1:0] q_in,
    input  logic [W:0]   d,
    output logic [W+1:0] r_out,
    output logic [W-1:0] q_out
);

    logic [W+1:0] r_sh;
    logic [W+1:0] d_ext;

    always_comb begin
        // {R,Q} shifted left by one: top dividend bit moves into R.
        r_sh  = {r_in[W:0], q_in[W-1]};
        d_ext = {1'b0, d};
        // Sign of the incoming remainder picks subtract or add-back.
        r_out = r_in[W+1] ? (r_sh + d_ext) : (r_sh - d_ext);
        q_out = {q_in[W-2:0], ~r_out[W+1]};
    end

endmodule

// File: rtl/seq_booth_divider.sv
// Sequential signed divider with C semantics (quotient truncates toward zero,
// remainder takes the dividend's sign). Non-restoring division on magnitudes,
// signs applied at the end. Fixed latency of WIDTH+3 cycles, special cases included.
// Handshake: start is accepted only when idle and not in the done cycle;
// busy is high while an operation is in flight; done pulses for one cycle
// and the results/flags are held until the next operation completes.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : request, sampled only in IDLE
//   dividend, divisor     : signed operands, captured on acceptance
//   busy, done            : status
//   quotient, remainder   : signed results
//   div_by_zero, overflow : result flags
//   dbg_state             : current FSM state (observation only)
module seq_booth_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output state_t           dbg_state
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic [WIDTH+1:0]   racc_q, racc_d;
    logic [WIDTH-1:0]   qacc_q, qacc_d;
    logic [WIDTH:0]     dmag_q, dmag_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH+1:0]   step_r;
    logic [WIDTH-1:0]   step_q;
    logic [WIDTH-1:0]   r_mag;

    div_nr_step #(.W(WIDTH)) u_step (
        .r_in  (racc_q),
        .q_in  (qacc_q),
        .d     (dmag_q),
        .r_out (step_r),
        .q_out (step_q)
    );

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        racc_d      = racc_q;
        qacc_d      = qacc_q;
        dmag_d      = dmag_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        // Final remainder correction; |R| < D <= 2^(WIDTH-1), so the low
        // WIDTH bits of the corrected value are the exact magnitude.
        r_mag = racc_q[WIDTH+1] ? (racc_q[WIDTH-1:0] + dmag_q[WIDTH-1:0])
                                : racc_q[WIDTH-1:0];

        unique case (state_q)
            IDLE: begin
                // The done cycle is excluded so back-to-back requests see a gap.
                if (start && !done_q) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    qsign_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rsign_d = dividend[WIDTH-1];
                    state_d = PREP;
                end
            end
            PREP: begin
                racc_d  = '0;
                qacc_d  = WIDTH'(abs_ext(64'($signed(dvd_q))));
                dmag_d  = (WIDTH+1)'(abs_ext(64'($signed(dvs_q))));
                cnt_d   = CNT_INIT;
                state_d = ITER;
            end
            ITER: begin
                racc_d = step_r;
                qacc_d = step_q;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                end else if ((dvd_q == MIN_VAL) && (dvs_q == '1)) begin
                    quotient_d  = MIN_VAL;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b1;
                end else begin
                    quotient_d  = qsign_q ? -qacc_q : qacc_q;
                    remainder_d = rsign_q ? -r_mag : r_mag;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            racc_q      <= '0;
            qacc_q      <= '0;
            dmag_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            racc_q      <= racc_d;
            qacc_q      <= qacc_d;
            dmag_q      <= dmag_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_booth_divider.sv
// Bench for seq_booth_divider: directed and random divisions, expected results
// pushed on issue and popped by an independent monitor on every done.
module tb_seq_booth_divider;
    import div_pkg::*;

    localparam int W     = 32;
    localparam int MIN_I = int'(32'h8000_0000);
    localparam int MAX_I = int'(32'h7fff_ffff);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;
    state_t       dbg_state;

    seq_booth_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_quo_q[$];
    logic [W-1:0] exp_rem_q[$];
    logic [1:0]   exp_flags_q[$];
    int           exp_cyc_q[$];
    int           op_a_q[$];
    int           op_b_q[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s (t=%0t)", name, detail, $time);
    endtask

    // C-style reference: plain integer division on 32-bit ints.
    task automatic ref_div(input int a, input int b, output int q, output int r,
                           output bit dz, output bit ov);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = -1;
            r  = a;
            dz = 1'b1;
        end else if (a == MIN_I && b == -1) begin
            q  = MIN_I;
            r  = 0;
            ov = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((busy || done) && n < 200) begin
            tick();
            n++;
        end
        check(!(busy || done), "idle_timeout",
              $sformatf("busy=%0b done=%0b after %0d cycles, required idle", busy, done, n));
    endtask

    task automatic issue(input int a, input int b);
        int q;
        int r;
        bit dz;
        bit ov;
        wait_ready();
        ref_div(a, b, q, r, dz, ov);
        exp_quo_q.push_back(q);
        exp_rem_q.push_back(r);
        exp_flags_q.push_back({dz, ov});
        exp_cyc_q.push_back(cyc + W + 3);
        op_a_q.push_back(a);
        op_b_q.push_back(b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        // Scramble the operand inputs; the DUT must have latched them already.
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] held_q;
    logic [W-1:0] held_r;
    logic         held_dz;
    logic         held_ov;
    bit           prev_done;

    always @(negedge clk) begin
        if (rst) begin
            held_q    = '0;
            held_r    = '0;
            held_dz   = 1'b0;
            held_ov   = 1'b0;
            prev_done = 1'b0;
        end else if (done) begin
            check(!prev_done, "done_pulse_width", "done high two cycles in a row, required one");
            check(!busy, "busy_at_done", $sformatf("busy=%0b, required 0", busy));
            check(exp_quo_q.size() != 0, "spurious_done", "done with no operation outstanding");
            if (exp_quo_q.size() != 0) begin
                logic [W-1:0] eq;
                logic [W-1:0] er;
                logic [1:0]   ef;
                int           ec;
                int           a;
                int           b;
                longint       lhs;
                longint       ra;
                longint       ba;
                eq = exp_quo_q.pop_front();
                er = exp_rem_q.pop_front();
                ef = exp_flags_q.pop_front();
                ec = exp_cyc_q.pop_front();
                a  = op_a_q.pop_front();
                b  = op_b_q.pop_front();
                check(quotient == eq, "quotient",
                      $sformatf("%0d/%0d got %0d, required %0d", a, b, int'(quotient), int'(eq)));
                check(remainder == er, "remainder",
                      $sformatf("%0d/%0d got %0d, required %0d", a, b, int'(remainder), int'(er)));
                check({div_by_zero, overflow} == ef, "flags",
                      $sformatf("%0d/%0d got dbz=%0b ovf=%0b, required dbz=%0b ovf=%0b",
                                a, b, div_by_zero, overflow, ef[1], ef[0]));
                check(cyc == ec, "latency",
                      $sformatf("%0d/%0d done at cycle %0d, required %0d", a, b, cyc, ec));
                if (ef == 2'b00) begin
                    lhs = longint'(int'(quotient)) * longint'(b) + longint'(int'(remainder));
                    check(lhs == longint'(a), "invariant",
                          $sformatf("q*d+r=%0d, required %0d", lhs, a));
                    ra = longint'(int'(remainder));
                    ba = longint'(b);
                    if (ra < 0) ra = -ra;
                    if (ba < 0) ba = -ba;
                    check(ra < ba, "rem_bound", $sformatf("|r|=%0d, required < %0d", ra, ba));
                end
            end
            held_q    = quotient;
            held_r    = remainder;
            held_dz   = div_by_zero;
            held_ov   = overflow;
            prev_done = 1'b1;
        end else begin
            check(quotient == held_q && remainder == held_r &&
                  div_by_zero == held_dz && overflow == held_ov, "outputs_hold",
                  $sformatf("q=%0d r=%0d dbz=%0b ovf=%0b changed, required q=%0d r=%0d dbz=%0b ovf=%0b",
                            int'(quotient), int'(remainder), div_by_zero, overflow,
                            int'(held_q), int'(held_r), held_dz, held_ov));
            prev_done = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int a;
        int b;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        check(quotient == '0 && remainder == '0, "reset_results",
              $sformatf("q=%0d r=%0d, required 0 0", int'(quotient), int'(remainder)));
        check(!busy && !done && !div_by_zero && !overflow, "reset_status",
              $sformatf("busy=%0b done=%0b dbz=%0b ovf=%0b, required all 0",
                        busy, done, div_by_zero, overflow));
        check(dbg_state == IDLE, "reset_state", $sformatf("state=%0d, required IDLE", dbg_state));
        rst = 1'b0;
        tick();

        // Directed cases
        issue(60, 5);
        issue(-10, 2);
        issue(7, -2);
        issue(-7, 2);
        issue(-20, -11);
        issue(100, 0);
        issue(MIN_I, -1);
        issue(MIN_I, 1);
        issue(0, 17);
        issue(0, 0);
        issue(MAX_I, MIN_I);
        issue(MIN_I, MIN_I);

        // Random cases
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = int'($urandom_range(0, 200)) - 100; b = int'($urandom_range(0, 30)) - 15; end
                2: begin a = $urandom; b = 0; end
                3: begin a = $urandom; b = int'($urandom_range(0, 1)) * 2 - 1; end
                4: begin a = MIN_I; b = $urandom; end
                default: begin a = $urandom; b = int'($urandom_range(1, 1000)); end
            endcase
            issue(a, b);
        end

        // start while busy is ignored; start during done is ignored
        issue(60, 5);
        for (int i = 0; i < 4; i++) begin
            repeat (2) tick();
            dividend = 9;
            divisor  = 3;
            start    = 1'b1;
            tick();
            start    = 1'b0;
        end
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check(done, "done_timeout", $sformatf("done=%0b after %0d cycles, required 1", done, n));
        dividend = 9;
        divisor  = 3;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check(!busy, "start_during_done", $sformatf("busy=%0b, required 0", busy));
        repeat (W + 6) tick();

        // Reset in the middle of ITER aborts with no done
        issue(1234, 7);
        n = 0;
        while (dbg_state != ITER && n < 10) begin
            tick();
            n++;
        end
        check(dbg_state == ITER, "reach_iter", $sformatf("state=%0d, required ITER", dbg_state));
        repeat (10) tick();
        rst = 1'b1;
        exp_quo_q.delete();
        exp_rem_q.delete();
        exp_flags_q.delete();
        exp_cyc_q.delete();
        op_a_q.delete();
        op_b_q.delete();
        tick();
        rst = 1'b0;
        check(quotient == '0 && remainder == '0, "abort_results",
              $sformatf("q=%0d r=%0d, required 0 0", int'(quotient), int'(remainder)));
        check(!busy && !done && !div_by_zero && !overflow, "abort_status",
              $sformatf("busy=%0b done=%0b dbz=%0b ovf=%0b, required all 0",
                        busy, done, div_by_zero, overflow));
        repeat (W + 6) tick();
        issue(MAX_I, MIN_I);

        // Drain
        n = 0;
        while (exp_quo_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(exp_quo_q.size() == 0, "drain",
              $sformatf("%0d results outstanding, required 0", exp_quo_q.size()));
        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
